// File: rtl/pacote_izero.sv
// pacote_izero: constants shared across the iZero datapath and control unit
package pacote_izero;
    localparam int LARGURA_DADO = 32;
    localparam logic [3:0] OPCODE_OUT = 4'hE;
endpackage

// File: rtl/fifo_circular.sv
// fifo_circular: circular buffer with read/write pointers and an occupancy counter
module fifo_circular #(
    parameter int LARGURA = 32,
    parameter int PROFUNDIDADE = 4,
    localparam int PW = $clog2(PROFUNDIDADE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [LARGURA-1:0] dado_entrada,
    output logic [LARGURA-1:0] dado_saida,
    output logic [PW:0]        contagem,
    output logic               vazio,
    output logic               cheio
);
    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PW-1:0] ptr_leitura, ptr_escrita;
    assign vazio = contagem == '0;
    assign cheio = contagem == (PW+1)'(PROFUNDIDADE);
    assign dado_saida = mem[ptr_leitura];
    // Power-of-two depth lets pointers wrap by natural overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_leitura <= '0;
            ptr_escrita <= '0;
            contagem <= '0;
        end else begin
            if (push) ptr_escrita <= ptr_escrita + 1'b1;
            if (pop) ptr_leitura <= ptr_leitura + 1'b1;
            contagem <= contagem + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[ptr_escrita] <= dado_entrada;
    end
endmodule

// File: rtl/controlador_saida_dados.sv
// controlador_saida_dados: OUT-instruction FIFO feeding an external peripheral
// over a valid/accept handshake, with stall and sticky overflow flag.
module controlador_saida_dados
    import pacote_izero::*;
#(
    parameter int LARGURA = LARGURA_DADO,
    parameter int PROFUNDIDADE = 4,
    localparam int PW = $clog2(PROFUNDIDADE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_saida,
    input  logic [LARGURA-1:0] dado_br,
    output logic               ocupado,
    output logic               saida_valida,
    output logic [LARGURA-1:0] saida_dado,
    input  logic               saida_aceita,
    output logic [PW:0]        contagem,
    output logic               erro_estouro
);
    logic vazio, cheio, push, pop;
    logic [LARGURA-1:0] dado_fifo;
    // Admission depends only on fullness, even if a pop frees a slot this cycle
    assign push = ctrl_saida && !cheio;
    assign pop = saida_aceita && !vazio;
    assign ocupado = cheio;
    assign saida_valida = !vazio;
    assign saida_dado = vazio ? '0 : dado_fifo;
    fifo_circular #(.LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .dado_entrada(dado_br),
        .dado_saida(dado_fifo),
        .contagem(contagem),
        .vazio(vazio),
        .cheio(cheio)
    );
    always_ff @(posedge clock) begin
        if (reset) erro_estouro <= 1'b0;
        else if (ctrl_saida && cheio) erro_estouro <= 1'b1;
    end
endmodule

// File: tb/tb_controlador_saida_dados.sv
// tb_controlador_saida_dados: directed and random stimulus checked against a queue model
module tb_controlador_saida_dados;
    import pacote_izero::*;
    localparam int W = LARGURA_DADO;
    localparam int D = 4;
    logic clock = 0;
    logic reset, ctrl_saida, saida_aceita;
    logic [W-1:0] dado_br, saida_dado;
    logic ocupado, saida_valida, erro_estouro;
    logic [2:0] contagem;
    int n_testes = 0, n_falhas = 0;
    logic [W-1:0] fila[$];
    bit m_erro;

    controlador_saida_dados #(.LARGURA(W), .PROFUNDIDADE(D)) dut (
        .clock(clock),
        .reset(reset),
        .ctrl_saida(ctrl_saida),
        .dado_br(dado_br),
        .ocupado(ocupado),
        .saida_valida(saida_valida),
        .saida_dado(saida_dado),
        .saida_aceita(saida_aceita),
        .contagem(contagem),
        .erro_estouro(erro_estouro)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [W-1:0] obs, input logic [W-1:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: obtido %0h esperado %0h", tag, obs, esp);
        end
    endtask

    task automatic confere();
        verifica("contagem", W'(contagem), W'(fila.size()));
        verifica("ocupado", W'(ocupado), W'(fila.size() == D));
        verifica("saida_valida", W'(saida_valida), W'(fila.size() != 0));
        verifica("saida_dado", saida_dado, fila.size() != 0 ? fila[0] : '0);
        verifica("erro_estouro", W'(erro_estouro), W'(m_erro));
    endtask

    task automatic ciclo(input bit r, input bit s, input logic [W-1:0] d, input bit a);
        bit cheia, tira;
        @(negedge clock);
        reset = r;
        ctrl_saida = s;
        dado_br = d;
        saida_aceita = a;
        confere();
        @(posedge clock);
        if (r) begin
            fila.delete();
            m_erro = 0;
        end else begin
            cheia = fila.size() == D;
            tira = a && fila.size() != 0;
            if (s && cheia) m_erro = 1;
            if (tira) void'(fila.pop_front());
            if (s && !cheia) fila.push_back(d);
        end
    endtask

    initial begin
        reset = 1;
        ctrl_saida = 0;
        dado_br = '0;
        saida_aceita = 0;
        m_erro = 0;
        repeat (2) @(posedge clock);
        ciclo(0, 0, 0, 0);
        ciclo(0, 0, 0, 0);
        ciclo(0, 1, 32'h0000_00AA, 1);
        ciclo(0, 0, 0, 1);
        ciclo(0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) ciclo(0, 1, W'(i), 0);
        for (int i = 0; i < 6; i++) ciclo(0, 0, 0, 1);
        ciclo(1, 0, 0, 0);
        ciclo(0, 1, 32'h10, 0);
        ciclo(0, 1, 32'h11, 0);
        for (int i = 0; i < 10; i++) ciclo(0, 1, W'(32'h20 + i), 1);
        for (int i = 0; i < 3; i++) ciclo(0, 0, 0, 1);
        ciclo(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) ciclo(0, 1, W'(32'h40 + i), 0);
        ciclo(0, 1, 32'h99, 1);
        ciclo(0, 0, 0, 0);
        ciclo(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) ciclo(0, 1, W'(32'h50 + i), 0);
        ciclo(1, 1, 32'h77, 1);
        ciclo(0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            ciclo($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1);
        @(negedge clock);
        confere();
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end
endmodule
